// File: rtl/afe_pkg.sv
// Shared constants and FSM state type for the optical front-end capture path.
// The front-end controller uses the same widths for its settings bus.
package afe_pkg;
    localparam int ADC_W = 8;
    localparam int DC_W  = 7;
    localparam int PGA_W = 4;
    localparam int SET_W = 2 + DC_W + PGA_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        ACCUM  = 2'd2
    } afe_state_e;
endpackage

// File: rtl/afe_avg_accum.sv
// Power-of-two window accumulator with sticky saturation tracking.
// Saturation detection is compiled in only when SAT_DETECT_EN is defined.
module afe_avg_accum
    import afe_pkg::*;
#(
    parameter int AVG_LOG2 = 3,
    parameter int SAT_HI   = 250,
    parameter int SAT_LO   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             accept,
    input  logic [ADC_W-1:0] adc,
    output logic             done,
    output logic [ADC_W-1:0] avg,
    output logic             win_sat_hi,
    output logic             win_sat_lo
);
    localparam int SUM_W = ADC_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    logic [SUM_W-1:0] sum_p0;
    logic [SUM_W-1:0] sum_nxt;
    logic [CNT_W-1:0] cnt_p0;

    // avg and done describe the window as it would be after the current sample
    assign sum_nxt = sum_p0 + SUM_W'(adc);
    assign done    = accept && (cnt_p0 == CNT_LAST);
    assign avg     = sum_nxt[SUM_W-1:AVG_LOG2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_p0 <= '0;
            cnt_p0 <= '0;
        end else if (clr || done) begin
            sum_p0 <= '0;
            cnt_p0 <= '0;
        end else if (accept) begin
            sum_p0 <= sum_nxt;
            cnt_p0 <= cnt_p0 + CNT_W'(1);
        end
    end

`ifdef SAT_DETECT_EN
    localparam logic [ADC_W-1:0] SAT_HI_C = ADC_W'(SAT_HI);
    localparam logic [ADC_W-1:0] SAT_LO_C = ADC_W'(SAT_LO);

    function automatic logic is_sat_hi(input logic [ADC_W-1:0] code);
        return code >= SAT_HI_C;
    endfunction

    function automatic logic is_sat_lo(input logic [ADC_W-1:0] code);
        return code <= SAT_LO_C;
    endfunction

    logic hi_sticky_p0;
    logic lo_sticky_p0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_sticky_p0 <= 1'b0;
            lo_sticky_p0 <= 1'b0;
        end else if (clr || done) begin
            hi_sticky_p0 <= 1'b0;
            lo_sticky_p0 <= 1'b0;
        end else if (accept) begin
            hi_sticky_p0 <= hi_sticky_p0 | is_sat_hi(adc);
            lo_sticky_p0 <= lo_sticky_p0 | is_sat_lo(adc);
        end
    end

    assign win_sat_hi = hi_sticky_p0 | is_sat_hi(adc);
    assign win_sat_lo = lo_sticky_p0 | is_sat_lo(adc);
`else
    assign win_sat_hi = 1'b0;
    assign win_sat_lo = 1'b0;
`endif
endmodule

// File: rtl/afe_sample_capture.sv
// Settle-then-average capture of ADC samples per active LED channel.
// Optional saturation flags are enabled with the SAT_DETECT_EN macro.
module afe_sample_capture
    import afe_pkg::*;
#(
    parameter int SETTLE_CYCLES = 16,
    parameter int AVG_LOG2      = 3,
    parameter int SAT_HI        = 250,
    parameter int SAT_LO        = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ADC_W-1:0] adc,
    input  logic             adc_valid,
    input  logic             led_ir,
    input  logic             led_red,
    input  logic [DC_W-1:0]  dc_comp,
    input  logic [PGA_W-1:0] pga_gain,
    output logic [ADC_W-1:0] ir_sample,
    output logic             ir_valid,
    output logic [ADC_W-1:0] red_sample,
    output logic             red_valid,
    output logic             sat_hi,
    output logic             sat_lo,
    output logic             settled
);
    localparam int TMR_W = 10;
    localparam logic [TMR_W-1:0] SETTLE_INIT = TMR_W'(SETTLE_CYCLES);

    afe_state_e       state, state_nxt;
    logic [TMR_W-1:0] tmr, tmr_nxt;
    logic [SET_W-1:0] set_cur, set_q;
    logic             change, legal, accept, clr, done, win_hi, win_lo;
    logic [ADC_W-1:0] avg;

    assign set_cur = {led_ir, led_red, dc_comp, pga_gain};
    assign change  = (set_cur != set_q);
    assign legal   = led_ir ^ led_red;
    assign accept  = (state == ACCUM) && legal && !change && adc_valid;
    assign clr     = (state != ACCUM) || !legal || change;
    assign settled = (state == ACCUM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            tmr   <= '0;
            set_q <= '0;
        end else begin
            state <= state_nxt;
            tmr   <= tmr_nxt;
            set_q <= set_cur;
        end
    end

    // Leaving SETTLE when the timer is at 1 (or 0) makes the first accepted
    // sample land exactly SETTLE_CYCLES edges after the settle was entered.
    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        if (!legal) begin
            state_nxt = IDLE;
        end else if (state == IDLE || change) begin
            state_nxt = SETTLE;
            tmr_nxt   = SETTLE_INIT;
        end else if (state == SETTLE) begin
            if (tmr <= TMR_W'(1)) state_nxt = ACCUM;
            else                  tmr_nxt   = tmr - TMR_W'(1);
        end
    end

    afe_avg_accum #(
        .AVG_LOG2 (AVG_LOG2),
        .SAT_HI   (SAT_HI),
        .SAT_LO   (SAT_LO)
    ) u_accum (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .accept     (accept),
        .adc        (adc),
        .done       (done),
        .avg        (avg),
        .win_sat_hi (win_hi),
        .win_sat_lo (win_lo)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_sample  <= '0;
            ir_valid   <= 1'b0;
            red_sample <= '0;
            red_valid  <= 1'b0;
            sat_hi     <= 1'b0;
            sat_lo     <= 1'b0;
        end else begin
            ir_valid  <= 1'b0;
            red_valid <= 1'b0;
            if (done) begin
                if (led_ir) begin
                    ir_sample <= avg;
                    ir_valid  <= 1'b1;
                end else begin
                    red_sample <= avg;
                    red_valid  <= 1'b1;
                end
                sat_hi <= win_hi;
                sat_lo <= win_lo;
            end
        end
    end
endmodule

// File: tb/tb_afe_sample_capture.sv
// Randomized and directed bench for afe_sample_capture against a window-level model.
module tb_afe_sample_capture;
    localparam int SC  = 16;
    localparam int AL  = 3;
    localparam int WIN = 1 << AL;
    localparam int SD  = (SC > 0) ? SC : 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] adc = '0;
    logic       adc_valid = 1'b0;
    logic       led_ir = 1'b0;
    logic       led_red = 1'b0;
    logic [6:0] dc_comp = '0;
    logic [3:0] pga_gain = '0;
    logic [7:0] ir_sample, red_sample;
    logic       ir_valid, red_valid, sat_hi, sat_lo, settled;

    afe_sample_capture #(
        .SETTLE_CYCLES (SC),
        .AVG_LOG2      (AL),
        .SAT_HI        (250),
        .SAT_LO        (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .adc        (adc),
        .adc_valid  (adc_valid),
        .led_ir     (led_ir),
        .led_red    (led_red),
        .dc_comp    (dc_comp),
        .pga_gain   (pga_gain),
        .ir_sample  (ir_sample),
        .ir_valid   (ir_valid),
        .red_sample (red_sample),
        .red_valid  (red_valid),
        .sat_hi     (sat_hi),
        .sat_lo     (sat_lo),
        .settled    (settled)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: a settings epoch starts at the edge where legal settings first
    // appear or change; samples count from SD edges later, in groups of WIN.
    int         e = 0;
    bit         m_run;
    int         m_first;
    logic [12:0] m_sq;
    int         win[$];
    int         m_ir, m_red, m_irv, m_redv, m_shi, m_slo;

    task automatic model_reset();
        m_run = 0; m_first = 0; m_sq = '0; win.delete();
        m_ir = 0; m_red = 0; m_irv = 0; m_redv = 0; m_shi = 0; m_slo = 0;
    endtask

    task automatic model_edge();
        logic [12:0] s;
        int sum, hi, lo;
        s = {led_ir, led_red, dc_comp, pga_gain};
        m_irv = 0; m_redv = 0;
        if (led_ir == led_red) begin
            m_run = 0; win.delete();
        end else if (!m_run || s != m_sq) begin
            m_run = 1; m_first = e + 1 + SD; win.delete();
        end else if (e >= m_first && adc_valid) begin
            win.push_back(int'(adc));
            if (win.size() == WIN) begin
                sum = 0; hi = 0; lo = 0;
                foreach (win[i]) begin
                    sum += win[i];
                    if (win[i] >= 250) hi = 1;
                    if (win[i] <= 5) lo = 1;
                end
                if (led_ir) begin m_ir = sum / WIN; m_irv = 1; end
                else begin m_red = sum / WIN; m_redv = 1; end
`ifdef SAT_DETECT_EN
                m_shi = hi; m_slo = lo;
`else
                m_shi = 0; m_slo = 0;
`endif
                win.delete();
            end
        end
        m_sq = s;
    endtask

    int stepno, p_ir, p_red, last_ir, last_red;

    task automatic step();
        int exp_settled;
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        exp_settled = (m_run && e >= m_first - 1) ? 1 : 0;
        e++;
        #1;
        chk("ir_valid", 32'(ir_valid), 32'(m_irv));
        chk("red_valid", 32'(red_valid), 32'(m_redv));
        chk("ir_sample", 32'(ir_sample), 32'(m_ir));
        chk("red_sample", 32'(red_sample), 32'(m_red));
        chk("sat_hi", 32'(sat_hi), 32'(m_shi));
        chk("sat_lo", 32'(sat_lo), 32'(m_slo));
        chk("settled", 32'(settled), 32'(exp_settled));
        if (ir_valid) begin p_ir++; last_ir = stepno; end
        if (red_valid) begin p_red++; last_red = stepno; end
        stepno++;
    endtask

    task automatic phase_start();
        stepno = 0; p_ir = 0; p_red = 0; last_ir = -1; last_red = -1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ir_sample"}, 32'(ir_sample), 0);
        chk({tag, "_ir_valid"}, 32'(ir_valid), 0);
        chk({tag, "_red_sample"}, 32'(red_sample), 0);
        chk({tag, "_red_valid"}, 32'(red_valid), 0);
        chk({tag, "_sat_hi"}, 32'(sat_hi), 0);
        chk({tag, "_sat_lo"}, 32'(sat_lo), 0);
        chk({tag, "_settled"}, 32'(settled), 0);
    endtask

    initial begin
        model_reset();
        #12;
        chk_all_zero("reset");
        step();
        rst = 1'b0;

        // Steady IR at 100: one publish 24 edges after settings appear
        led_ir = 1'b1; dc_comp = 7'd64; pga_gain = 4'd0; adc = 8'd100; adc_valid = 1'b1;
        phase_start();
        repeat (30) step();
        chk("a_pulses", 32'(p_ir), 1);
        chk("a_when", 32'(last_ir), 24);
        chk("a_sample", 32'(ir_sample), 100);
        chk("a_sat_hi", 32'(sat_hi), 0);

        // Window 10..17 averages to 13
        dc_comp = 7'd65; adc_valid = 1'b0;
        phase_start();
        repeat (SC + 1) step();
        for (int i = 0; i < WIN; i++) begin
            adc = 8'(10 + i); adc_valid = 1'b1;
            step();
        end
        adc_valid = 1'b0;
        step();
        chk("b_pulses", 32'(p_ir), 1);
        chk("b_when", 32'(last_ir), 24);
        chk("b_sample", 32'(ir_sample), 13);

        // Change after 5 samples discards the window
        dc_comp = 7'd66;
        phase_start();
        repeat (SC + 1) step();
        adc = 8'd50; adc_valid = 1'b1;
        repeat (5) step();
        chk("c_no_early", 32'(p_ir), 0);
        dc_comp = 7'd48; adc = 8'd60;
        phase_start();
        repeat (30) step();
        chk("c_pulses", 32'(p_ir), 1);
        chk("c_when", 32'(last_ir), 24);
        chk("c_sample", 32'(ir_sample), 60);

        // Switch to RED at full scale
        led_ir = 1'b0; led_red = 1'b1; adc = 8'd255;
        phase_start();
        repeat (30) step();
        chk("d_red_pulses", 32'(p_red), 1);
        chk("d_ir_pulses", 32'(p_ir), 0);
        chk("d_when", 32'(last_red), 24);
        chk("d_red_sample", 32'(red_sample), 255);
        chk("d_ir_kept", 32'(ir_sample), 60);
`ifdef SAT_DETECT_EN
        chk("d_sat_hi", 32'(sat_hi), 1);
`else
        chk("d_sat_hi", 32'(sat_hi), 0);
`endif

        // Both LEDs on is illegal
        led_ir = 1'b1; led_red = 1'b1;
        phase_start();
        repeat (20) step();
        chk("e_settled", 32'(settled), 0);
        chk("e_pulses", 32'(p_ir + p_red), 0);

        // Random traffic with occasional settings and LED changes
        led_ir = 1'b1; led_red = 1'b0;
        phase_start();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 63) == 0) begin
                dc_comp = 7'($urandom);
                pga_gain = 4'($urandom);
            end
            if ($urandom_range(0, 127) == 0) begin
                led_ir = 1'($urandom);
                led_red = 1'($urandom);
            end
            case ($urandom_range(0, 5))
                0: adc = 8'($urandom_range(250, 255));
                1: adc = 8'($urandom_range(0, 5));
                default: adc = 8'($urandom);
            endcase
            adc_valid = ($urandom_range(0, 3) != 0);
            step();
        end
        chk("r_some_pulses", 32'((p_ir + p_red) > 0), 1);

        // Asynchronous reset in the middle of an IR window
        led_ir = 1'b1; led_red = 1'b0; dc_comp = 7'd10; adc = 8'd200; adc_valid = 1'b1;
        phase_start();
        repeat (SC + WIN + 4) step();
        chk("f_pre_sample", 32'(ir_sample), 200);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk_all_zero("async_rst");
        step();
        rst = 1'b0;
        phase_start();
        repeat (30) step();
        chk("f_post_pulses", 32'(p_ir), 1);
        chk("f_post_when", 32'(last_ir), 24);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
